// File: rtl/demux_pkg.sv
// Shared types for the 1-to-4 buffered demux: channel count, index type, slot state.
package demux_pkg;
  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;
endpackage

// File: rtl/demux_slot.sv
// One-entry registered holding slot with valid/ready. A load while full (draining)
// overwrites in place, so a ready consumer sees back-to-back words.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] q
);
  slot_state_e state, state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Data is not cleared on drain; it holds the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load)           state_nxt = FULL;
      FULL:    if (ready && !load) state_nxt = EMPTY;
      default:                     state_nxt = EMPTY;
    endcase
  end

  assign valid = (state == FULL);
endmodule

// File: rtl/demux_1_to_4_buf.sv
// 1-to-4 demux with per-channel one-entry buffers, manual (S) or round-robin routing.
// Optional per-channel accept counters on TX_COUNT when DEMUX_COUNT_EN is defined.
module demux_1_to_4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef DEMUX_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  D,
  input  logic              D_VALID,
  output logic              D_READY,
  input  logic [1:0]        S,
  input  logic              AUTO,
  output logic [WIDTH-1:0]  Y1,
  output logic [WIDTH-1:0]  Y2,
  output logic [WIDTH-1:0]  Y3,
  output logic [WIDTH-1:0]  Y4,
  output logic [NUM_CH-1:0] Y_VALID,
  input  logic [NUM_CH-1:0] Y_READY
`ifdef DEMUX_COUNT_EN
  , output logic [NUM_CH*CNT_W-1:0] TX_COUNT
`endif
);
  ch_idx_t                       rr;
  ch_idx_t                       tgt;
  logic                          accept;
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH-1:0][WIDTH-1:0]  y_data;

  assign tgt     = AUTO ? rr : ch_idx_t'(S);
  // No skipping: a stalled target blocks the input even if other slots are empty.
  assign D_READY = !RST && (!Y_VALID[tgt] || Y_READY[tgt]);
  assign accept  = D_VALID && D_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                 rr <= '0;
    else if (accept && AUTO) rr <= rr + ch_idx_t'(1);
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load[i] = accept && (tgt == ch_idx_t'(i));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk   (CLK),
      .rst   (RST),
      .load  (load[i]),
      .d     (D),
      .ready (Y_READY[i]),
      .valid (Y_VALID[i]),
      .q     (y_data[i])
    );
  end

  assign Y1 = y_data[0];
  assign Y2 = y_data[1];
  assign Y3 = y_data[2];
  assign Y4 = y_data[3];

`ifdef DEMUX_COUNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt <= '0;
    else begin
      for (int i = 0; i < NUM_CH; i++)
        if (load[i]) cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  assign TX_COUNT = cnt;
`else
  // Counter-free build: no TX_COUNT port, no counter state.
`endif
endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// Directed bench for demux_1_to_4_buf; expected words queued per channel and
// checked by a monitor whenever a channel drains.
module tb_demux_1_to_4_buf;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] D = '0;
  logic       D_VALID = 1'b0;
  logic       D_READY;
  logic [1:0] S = '0;
  logic       AUTO = 1'b0;
  logic [7:0] Y1, Y2, Y3, Y4;
  logic [3:0] Y_VALID;
  logic [3:0] Y_READY = '0;

`ifdef DEMUX_COUNT_EN
  logic [7:0] TX_COUNT;
  demux_1_to_4_buf #(.WIDTH(8), .CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_READY(D_READY),
    .S(S), .AUTO(AUTO), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4),
    .Y_VALID(Y_VALID), .Y_READY(Y_READY), .TX_COUNT(TX_COUNT)
  );
`else
  demux_1_to_4_buf #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .D(D), .D_VALID(D_VALID), .D_READY(D_READY),
    .S(S), .AUTO(AUTO), .Y1(Y1), .Y2(Y2), .Y3(Y3), .Y4(Y4),
    .Y_VALID(Y_VALID), .Y_READY(Y_READY)
  );
`endif

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [4][$];

  function automatic logic [7:0] y_of(input int i);
    case (i)
      0:       return Y1;
      1:       return Y2;
      2:       return Y3;
      default: return Y4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Offer one word and hold it until accepted; then check it landed one cycle later.
  task automatic send(input logic [7:0] d, input logic [1:0] s, input logic a, input int ch);
    bit done = 1'b0;
    D = d; S = s; AUTO = a; D_VALID = 1'b1;
    exp_q[ch].push_back(d);
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge CLK);
      done = D_READY;
      @(posedge CLK);
      #1;
    end
    D_VALID = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ch%0d: got no accept in 50 cycles, expected accept", ch);
    end else begin
      chk($sformatf("lat_valid_ch%0d", ch), 32'(Y_VALID[ch]), 32'd1);
      chk($sformatf("lat_data_ch%0d", ch), 32'(y_of(ch)), 32'(d));
    end
  endtask

  // Monitor: every drained word must be the next one expected on that channel.
  always @(negedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) begin
        if (Y_VALID[i] && Y_READY[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ch%0d: got %0h expected no word", i, y_of(i));
          end else begin
            chk($sformatf("drain_ch%0d", i), 32'(y_of(i)), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Power-on reset values
    #2;
    chk("rst_ready", 32'(D_READY), 32'd0);
    chk("rst_valid", 32'(Y_VALID), 32'd0);
    chk("rst_y", {Y1, Y2, Y3, Y4}, 32'd0);
    idle(2);
    RST = 1'b0;
    @(negedge CLK);
    chk("rel_ready", 32'(D_READY), 32'd1);
    idle(1);

    // Reset asserted mid-transfer discards slot contents asynchronously
    Y_READY = 4'b0000;
    send(8'h77, 2'd3, 1'b0, 3);
    D = 8'h88; D_VALID = 1'b1;
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(Y_VALID), 32'd0);
    chk("mid_rst_y4", 32'(Y4), 32'd0);
    chk("mid_rst_ready", 32'(D_READY), 32'd0);
    exp_q[3].delete();
    D_VALID = 1'b0;
    idle(1);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rel_ready", 32'(D_READY), 32'd1);
    idle(1);

    // Manual routing, back-to-back
    Y_READY = 4'b1111;
    for (int i = 0; i < 4; i++) send(8'hA5, 2'(i), 1'b0, i);
    idle(2);

    // Round robin with wrap 3 -> 0
    for (int i = 0; i < 5; i++) send(8'(i + 1), 2'd0, 1'b1, i % 4);
    idle(2);

    // Backpressure on channel 3 then overwrite on drain
    Y_READY = 4'b0000;
    send(8'h11, 2'd2, 1'b0, 2);
    D = 8'h22; D_VALID = 1'b1;
    exp_q[2].push_back(8'h22);
    @(negedge CLK);
    chk("bp_ready_low", 32'(D_READY), 32'd0);
    chk("bp_hold_y3", 32'(Y3), 32'h11);
    chk("bp_valid", 32'(Y_VALID), 32'b0100);
    @(posedge CLK); #1;
    Y_READY = 4'b0100;
    @(negedge CLK);
    chk("bp_ready_high", 32'(D_READY), 32'd1);
    @(posedge CLK); #1;
    D_VALID = 1'b0;
    chk("bp_valid_kept", 32'(Y_VALID[2]), 32'd1);
    chk("bp_overwrite_y3", 32'(Y3), 32'h22);
    Y_READY = 4'b1111;
    idle(2);

    // Blocked target stalls input even with other channels empty
    Y_READY = 4'b0000;
    send(8'h33, 2'd0, 1'b0, 0);
    D = 8'h44; S = 2'd0; D_VALID = 1'b1;
    exp_q[1].push_back(8'h44);
    @(negedge CLK);
    chk("blk_ready_low", 32'(D_READY), 32'd0);
    @(posedge CLK); #1;
    S = 2'd1;
    @(negedge CLK);
    chk("blk_ready_switch", 32'(D_READY), 32'd1);
    @(posedge CLK); #1;
    D_VALID = 1'b0;
    chk("blk_valid", 32'(Y_VALID), 32'b0011);
    chk("blk_y2", 32'(Y2), 32'h44);
    Y_READY = 4'b1111;
    idle(2);

    // RR kept its value (1) across manual-mode traffic
    send(8'h55, 2'd3, 1'b1, 1);
    idle(2);

`ifdef DEMUX_COUNT_EN
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    idle(1);
    for (int k = 1; k <= 5; k++) begin
      send(8'(8'h60 + k), 2'd2, 1'b0, 2);
      chk($sformatf("cnt_ch2_%0d", k), 32'(TX_COUNT[5:4]), 32'(k % 4));
      chk($sformatf("cnt_other_%0d", k), 32'({TX_COUNT[7:6], TX_COUNT[3:0]}), 32'd0);
    end
    idle(2);
`endif

    for (int i = 0; i < 4; i++)
      chk($sformatf("q_empty_ch%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
